// File: rtl/adc_oversampler.sv
// adc_oversampler: paces SAR ADC conversions, captures each code a fixed
// delay after its start pulse, averages 2^OSR_LOG2 codes per result and
// presents results on a valid/ready port with a sticky overrun flag.
// Ports:
//   clk, reset_n          rising-edge clock, async active-low reset
//   enable                run conversions (0 aborts and idles)
//   adc_start             one-cycle start pulse to the ADC
//   adc_d                 ADC conversion code
//   out_data, out_valid   averaged result and its valid flag
//   out_ready             consumer accepts on out_valid && out_ready
//   overrun               sticky: a result was dropped while out_valid was high
module adc_oversampler #(
    parameter int ADC_W         = 10,
    parameter int CONV_CYCLES   = 12,
    parameter int SAMPLE_PERIOD = 32,
    parameter int OSR_LOG2      = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic             adc_start,
    input  logic [ADC_W-1:0] adc_d,
    output logic [ADC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam int ACC_W = ADC_W + OSR_LOG2;
    localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int SC_W  = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;

    localparam logic [CNT_W-1:0] CAP_AT   = CNT_W'(CONV_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [SC_W-1:0]  LAST_SMP = SC_W'((1 << OSR_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        WAIT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic [SC_W-1:0]  smp_q;
    logic             capture;
    logic             last;
    logic [ACC_W-1:0] sum;
    logic [ADC_W-1:0] result;

    // Accumulator is wide enough for 2^OSR_LOG2 full-scale codes.
    assign sum    = acc_q + ACC_W'(adc_d);
    assign result = ADC_W'(sum >> OSR_LOG2);
    // With OSR_LOG2 = 0 the sample count stays 0, so every capture is last.
    assign last   = capture && (smp_q == LAST_SMP);

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        adc_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = CONV;
            end
            CONV: begin
                adc_start = (cnt_q == '0);
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q == CAP_AT) begin
                    state_d = WAIT;
                    capture = 1'b1;
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = CONV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Period counter starts at 0 on the start-pulse cycle and wraps every
    // SAMPLE_PERIOD cycles, so starts stay exactly one period apart.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            smp_q <= '0;
        end else begin
            if (state_q == IDLE || state_d == IDLE) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST_CNT) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (state_d == IDLE) begin
                acc_q <= '0;
                smp_q <= '0;
            end else if (last) begin
                acc_q <= '0;
                smp_q <= '0;
            end else if (capture) begin
                acc_q <= sum;
                smp_q <= smp_q + 1'b1;
            end
        end
    end

    // A new result may load on the same edge the old one is handshaken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (last) begin
                if (!out_valid || out_ready) begin
                    out_data  <= result;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (state_q == IDLE && !enable) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_oversampler.sv
// tb_adc_oversampler: directed and random stimulus for adc_oversampler,
// checked every cycle against a time-based behavioural model.
module tb_adc_oversampler;

    localparam int W  = 10;
    localparam int CC = 12;
    localparam int SP = 32;
    localparam int OL = 2;
    localparam int N  = 1 << OL;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] adc_d = '0;
    logic         adc_start;
    logic         out_valid;
    logic         overrun;
    logic [W-1:0] out_data;

    int total = 0;
    int bad = 0;

    // model: run = converting, t = cycles since the first start pulse
    bit           run = 0;
    int           t = 0;
    int           samp[$];
    bit           m_valid = 0;
    logic [W-1:0] m_data = '0;
    bit           m_ovr = 0;
    int           results = 0;
    int           cyc = 0;
    int           cap_q[$];

    always #5 clk = ~clk;

    adc_oversampler #(
        .ADC_W(W),
        .CONV_CYCLES(CC),
        .SAMPLE_PERIOD(SP),
        .OSR_LOG2(OL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .adc_start(adc_start),
        .adc_d(adc_d),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun(overrun)
    );

    task automatic chk1(string tag, logic obs, logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(string tag, int obs, int exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive adc_d, check this cycle's outputs, advance the
    // model across the coming edge, then step to 1 time unit after it.
    task automatic tick();
        int s;
        bit got;
        bit hs;
        logic [W-1:0] res;
        if (run && (t % SP) == CC && cap_q.size() > 0)
            adc_d = W'(cap_q.pop_front());
        else
            adc_d = W'($urandom_range(0, 1023));

        chk1("adc_start", adc_start, run && (t % SP) == 0);
        chk1("out_valid", out_valid, m_valid);
        chkw("out_data", out_data, m_data);
        chk1("overrun", overrun, m_ovr);

        got = 0;
        res = '0;
        hs = m_valid && out_ready;
        if (!run) begin
            if (enable) begin
                run = 1;
                t = 0;
            end else begin
                m_ovr = 0;
            end
        end else if (!enable) begin
            run = 0;
            samp.delete();
        end else begin
            if ((t % SP) == CC) begin
                samp.push_back(int'(adc_d));
                if (samp.size() == N) begin
                    s = 0;
                    foreach (samp[i]) s += samp[i];
                    res = W'(s / N);
                    got = 1;
                    samp.delete();
                end
            end
            t++;
        end

        if (got) begin
            results++;
            if (!m_valid || out_ready) begin
                m_data = res;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (hs) begin
            m_valid = 0;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_results(int n, int bound);
        int r0;
        int k;
        r0 = results;
        k = 0;
        while (results < r0 + n && k < bound) begin
            tick();
            k++;
        end
        chki("result_timeout", results - r0, n);
    endtask

    initial begin
        int en_cyc;
        int first;
        int k;
        int starts;
        logic [W-1:0] v1;

        // reset state
        #1;
        chk1("rst_start", adc_start, 1'b0);
        chk1("rst_valid", out_valid, 1'b0);
        chkw("rst_data", out_data, '0);
        chk1("rst_ovr", overrun, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 1: constant mid-scale code, first result timing
        enable = 1'b1;
        out_ready = 1'b1;
        repeat (N) cap_q.push_back(10'h200);
        en_cyc = cyc;
        k = 0;
        tick();
        while (!out_valid && k < 200) begin
            tick();
            k++;
        end
        first = cyc;
        chki("t1_valid_cycle", first, en_cyc + 1 + 109);
        chkw("t1_data", out_data, 10'h200);
        tick();
        chk1("t1_one_cycle", out_valid, 1'b0);

        // 2: truncating average
        cap_q.push_back(1);
        cap_q.push_back(2);
        cap_q.push_back(3);
        cap_q.push_back(5);
        wait_results(1, 200);
        chkw("t2_avg", out_data, 10'd2);

        // 3: full scale, no wrap
        repeat (N) cap_q.push_back(10'h3FF);
        wait_results(1, 200);
        chkw("t3_full", out_data, 10'h3FF);

        // 4: held result and overrun
        out_ready = 1'b0;
        wait_results(1, 200);
        v1 = m_data;
        wait_results(1, 200);
        chk1("t4_ovr", overrun, 1'b1);
        chkw("t4_held", out_data, v1);
        chk1("t4_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1("t4_consumed", out_valid, 1'b0);

        // 5: abort at S+5 of the third sample, then re-enable
        k = 0;
        while (!(run && samp.size() == 2 && (t % SP) == 5) && k < 300) begin
            tick();
            k++;
        end
        chki("t5_reach", k < 300 ? 1 : 0, 1);
        enable = 1'b0;
        tick();
        starts = 0;
        repeat (100) begin
            if (adc_start) starts++;
            tick();
        end
        chki("t5_no_start", starts, 0);
        chk1("t5_ovr_clr", overrun, 1'b0);
        repeat (N) cap_q.push_back(10'h100);
        enable = 1'b1;
        wait_results(1, 200);
        chkw("t5_clean", out_data, 10'h100);

        // 6: async reset mid-CONV with a pending result
        k = 0;
        while (!(run && m_valid && (t % SP) == 5) && k < 200) begin
            tick();
            k++;
        end
        chki("t6_reach", k < 200 ? 1 : 0, 1);
        #2;
        reset_n = 1'b0;
        enable = 1'b0;
        #1;
        chk1("t6_start", adc_start, 1'b0);
        chk1("t6_valid", out_valid, 1'b0);
        chkw("t6_data", out_data, '0);
        chk1("t6_ovr", overrun, 1'b0);
        run = 0;
        t = 0;
        samp.delete();
        cap_q.delete();
        m_valid = 0;
        m_data = '0;
        m_ovr = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        chk1("t6_idle_restart", adc_start, 1'b1);

        // random traffic with occasional aborts
        repeat (1500) begin
            out_ready = ($urandom_range(0, 1) == 1);
            enable = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
